// File: rtl/rv_enc_pkg.sv
// Shared constants and types for the RV32I instruction encoder.
// Opcodes, request formats, funct7 values and FSM states.
package rv_enc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    FMT_LOAD   = 2'd0,
    FMT_STORE  = 2'd1,
    FMT_BRANCH = 2'd2,
    FMT_RTYPE  = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rv_enc_fifo2.sv
// Two-entry valid/ready FIFO; the head is held in
// registers that drive the consumer directly.
module rv_enc_fifo2 #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [1:0]   cnt_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         push;
  logic         pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;
  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // Occupancy and storage update; flush restores the reset head.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      cnt_q  <= 2'd0;
      head_q <= RST_VAL;
      tail_q <= RST_VAL;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            head_q <= in_data_i;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= in_data_i;
          end else if (push) begin
            tail_q <= in_data_i;
            cnt_q  <= 2'd2;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q <= tail_q;
            cnt_q  <= 2'd1;
          end
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// Turns symbolic LOAD/STORE/BRANCH/R-type requests into
// RV32I words tagged with sequential byte addresses.
module rv_instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_fmt,
  input  logic [3:0]        req_funct,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [12:0]       req_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            state_q;
  logic [CW-1:0]     count_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              done_q;

  fmt_e        fmt;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] instr;
  logic        bad;
  logic        hs;
  logic        push;
  logic        fifo_rdy;

  assign fmt = fmt_e'(req_fmt);
  assign f3  = req_funct[2:0];
  assign f7  = req_funct[3] ? F7_ALT : F7_BASE;

  // Field packing and malformed-request detection.
  always_comb begin
    instr = '0;
    bad   = 1'b0;
    unique case (fmt)
      FMT_LOAD: begin
        instr = {req_imm[11:0], req_rs1, f3,
                 req_rd, OP_LOAD};
        bad = req_imm[12] != req_imm[11];
      end
      FMT_STORE: begin
        instr = {req_imm[11:5], req_rs2, req_rs1,
                 f3, req_imm[4:0], OP_STORE};
        bad = req_imm[12] != req_imm[11];
      end
      FMT_BRANCH: begin
        instr = {req_imm[12], req_imm[10:5],
                 req_rs2, req_rs1, f3,
                 req_imm[4:1], req_imm[11],
                 OP_BRANCH};
        bad = req_imm[0];
      end
      FMT_RTYPE: begin
        instr = {f7, req_rs2, req_rs1, f3,
                 req_rd, OP_RTYPE};
        bad = req_funct[3] &&
              !(f3 == 3'b000 || f3 == 3'b101);
      end
    endcase
  end

  assign req_ready = (state_q == S_RUN) && fifo_rdy &&
                     (count_q < CW'(MAX_WORDS));
  // A start on the same edge discards the handshake.
  assign hs   = req_valid && req_ready && !start;
  assign push = hs && !bad;
  assign done = done_q;
  assign err  = err_q;

  // Sequencing FSM with address, count and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= BASE;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (start) begin
      state_q <= S_RUN;
      count_q <= '0;
      addr_q  <= BASE;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (hs && bad) err_q <= 1'b1;
      if (push) begin
        addr_q  <= addr_q + ADDR_W'(4);
        count_q <= count_q + CW'(1);
        if (count_q == CW'(MAX_WORDS - 1)) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
      end
    end
  end

  rv_enc_fifo2 #(
    .W       (ADDR_W + 32),
    .RST_VAL ({BASE, 32'h0})
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (start),
    .in_valid_i  (push),
    .in_ready_o  (fifo_rdy),
    .in_data_i   ({addr_q, instr}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  ({out_addr, out_instr})
  );

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Inverse of the control decoder: turns high-level instruction requests into 32-bit RV32I words carrying the OPCode/Funct fields the control path decodes.
- Covers the LOAD, STORE, BRANCH and R-type classes.
- Buffers encoded words in a 2-entry output FIFO and tags each with a sequential byte address.
- Sits between a test/program sequencer and the instruction-memory write port, so directed programs for the datapath come from symbolic requests rather than hand-packed hex.

Parameters:
- ADDR_W, 10, width of out_addr (byte address).
- BASE_ADDR, 0, byte address of the first emitted word after start.
- MAX_WORDS, 256, program length limit in words; must satisfy MAX_WORDS*4 <= 2**ADDR_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; restarts the address/count at BASE_ADDR and clears err/done.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_fmt  in  2  0=LOAD(0000011), 1=STORE(0100011), 2=BRANCH(1100011), 3=R-type(0110011).
- req_funct  in  4  {funct7[5], funct3}; same packing as the control unit's Funct.
- req_rd  in  5  destination register.
- req_rs1  in  5  source register 1.
- req_rs2  in  5  source register 2.
- req_imm  in  13  signed immediate.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts the word when out_valid&&out_ready.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- done  out  1  MAX_WORDS words have been accepted.
- err  out  1  sticky; a malformed request was dropped.

Behaviour:
- Reset:
  - req_ready=0, out_valid=0, out_instr=0, out_addr=BASE_ADDR, done=0, err=0.
  - FIFO is emptied, word count=0, FSM=IDLE.
  - Reset wins over every other input on the same edge, including mid-transfer; the FIFO contents are discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: req_ready=0; start -> RUN.
  - RUN: req_ready = (FIFO not full) && (count < MAX_WORDS).
  - RUN -> DONE on the edge the MAX_WORDS-th word is accepted.
  - DONE: req_ready=0; done=1; the FIFO still drains.
  - start in any state -> RUN, count=0, next address=BASE_ADDR, err=0, done=0. The FIFO is flushed; a start coincident with a request handshake drops that request.
- Latency: an accepted request appears at the FIFO head on the next cycle when the FIFO was empty; out_instr/out_addr are registered.
- Encoding (funct7 = req_funct[3] ? 0100000 : 0000000):
  - R: {funct7, rs2, rs1, funct3, rd, 0110011}.
  - LOAD: {imm[11:0], rs1, funct3, rd, 0000011}.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
- Validation: a request is malformed when any of the following holds:
  - LOAD/STORE and imm outside -2048..2047;
  - BRANCH and imm[0]=1;
  - R-type with funct[3]=1 and funct3 not in {000, 101}.
  - A malformed request is consumed but produces no word, does not advance the address or count, and sets err.
- Address: each well-formed accepted request takes the next address, then the address advances by 4; the address wraps modulo 2**ADDR_W.
- FIFO: 2 entries. Simultaneous push and pop while full is not possible because req_ready=0 when full. Push and pop in the same cycle at 1 entry keeps the occupancy at 1.
- Stability: out_instr and out_addr hold stable while out_valid && !out_ready.

Decomposition:
- Package rv_enc_pkg: opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE), the fmt enum, funct7 constants, FSM state enum.
- Sub-module rv_enc_fifo2: 2-entry valid/ready FIFO carrying {addr, instr}.
- Encode and validation logic stay combinational inside the top.

Test Plan:
- start; R fmt=3, funct=0000, rd=3, rs1=1, rs2=2 -> out_instr=0x002081B3, out_addr=0x000; then funct=1000 -> 0x402081B3 at 0x004.
- LOAD funct=0010, rd=5, rs1=2, imm=8 -> 0x00812283; STORE funct=0010, rs1=2, rs2=5, imm=12 -> 0x00512623.
- BRANCH funct=0000, rs1=1, rs2=2, imm=-8 -> 0xFE208CE3; BRANCH imm=3 -> no word, err=1, address unchanged.
- out_ready=0 with a continuous request stream -> exactly 2 words buffered, then req_ready=0; out_instr stable; release -> in-order drain with no loss.
- MAX_WORDS=4: issue 5 requests -> 4 accepted, done=1, req_ready=0; start -> out_addr restarts at BASE_ADDR, done=0.
- Reset asserted with 2 words buffered -> out_valid=0 next cycle, FSM=IDLE, req_ready=0.
